// File: rtl/muldiv_pkg.sv
// Shared definitions for the multicycle MULT/DIV unit: FSM states, op codes
// and default sizing.
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;
    localparam int MULDIV_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        ZERO = 2'd3
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

endpackage

// File: rtl/muldiv_if.sv
// Control-unit <-> MULT/DIV unit handshake and result bus.
// master = control unit side, slave = muldiv_unit side.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
);
    logic             start_mult;
    logic             start_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start_mult, start_div, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start_mult, start_div, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_datapath.sv
// Operand magnitudes, shared 2*WIDTH working register, one-bit-per-cycle
// shift-add / restoring-divide step, and the final sign fix-up into HI/LO.
//
// The working register acc is shared by both ops:
//   MULT: acc = {partial product, remaining multiplier bits}, m = |a|
//   DIV : acc = {partial remainder, dividend bits / quotient bits}, m = |b|
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  op_t              load_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             step,
    input  logic             fix,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    op_t                op_q;
    logic               sign_q;     // product / quotient sign
    logic               rsign_q;    // remainder sign (dividend sign)
    logic [WIDTH-1:0]   m_q;
    logic [2*WIDTH-1:0] acc_q;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     r_sh;
    logic [WIDTH:0]     r_diff;
    logic               r_ge;
    logic [2*WIDTH-1:0] acc_step;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   rem_mag;
    logic [WIDTH-1:0]   quo_mag;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;

    // Unsigned magnitudes; the most negative value maps onto itself.
    assign mag_a = a[WIDTH-1] ? -a : a;
    assign mag_b = b[WIDTH-1] ? -b : b;

    // One iteration of either shift-add multiply or restoring divide.
    always_comb begin
        add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
        r_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        r_diff  = r_sh - {1'b0, m_q};
        r_ge    = (r_sh >= {1'b0, m_q});
        if (op_q == OP_MULT) begin
            acc_step = {add_sum, acc_q[WIDTH-1:1]};
        end else begin
            acc_step = {(r_ge ? r_diff[WIDTH-1:0] : r_sh[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], r_ge};
        end
    end

    // Sign fix-up of the finished unsigned result.
    always_comb begin
        prod_fix = sign_q ? -acc_q : acc_q;
        rem_mag  = acc_q[2*WIDTH-1:WIDTH];
        quo_mag  = acc_q[WIDTH-1:0];
        if (op_q == OP_MULT) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
        end else begin
            hi_d = rsign_q ? -rem_mag : rem_mag;
            lo_d = sign_q  ? -quo_mag : quo_mag;
        end
    end

    // Operand latch on start, iterate in RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q    <= OP_MULT;
            sign_q  <= 1'b0;
            rsign_q <= 1'b0;
            m_q     <= '0;
            acc_q   <= '0;
        end else if (load) begin
            op_q    <= load_op;
            sign_q  <= a[WIDTH-1] ^ b[WIDTH-1];
            rsign_q <= a[WIDTH-1];
            m_q     <= (load_op == OP_MULT) ? mag_a : mag_b;
            acc_q   <= {{WIDTH{1'b0}}, ((load_op == OP_MULT) ? mag_b : mag_a)};
        end else if (step) begin
            acc_q   <= acc_step;
        end
    end

    // HI/LO only move on a completed FIX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (fix) begin
            hi <= hi_d;
            lo <= lo_d;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multicycle signed MULT/DIV responder. FSM, iteration counter and the
// start/busy/done handshake live here; arithmetic is in muldiv_datapath.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH,
    parameter int CNT_W = MULDIV_CNT_W
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             b_zero;
    logic             last_iter;

    logic             load;
    op_t              load_op;
    logic             step;
    logic             fix;
    logic             busy_d;
    logic             done_d;
    logic             dz_d;
    logic             busy_q;
    logic             done_q;
    logic             dz_q;

    assign b_zero    = (bus.b == '0);
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state; starts are only looked at in IDLE, MULT has priority.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start_mult)                state_d = RUN;
                else if (bus.start_div && b_zero)  state_d = ZERO;
                else if (bus.start_div)            state_d = RUN;
            end
            RUN:     if (last_iter) state_d = FIX;
            FIX:     state_d = IDLE;
            ZERO:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath controls and next values of the registered handshake outputs.
    always_comb begin
        load    = (state_q == IDLE) &&
                  (bus.start_mult || (bus.start_div && !b_zero));
        load_op = bus.start_mult ? OP_MULT : OP_DIV;
        step    = (state_q == RUN);
        fix     = (state_q == FIX);
        // busy covers RUN and the FIX cycle, so it drops with done.
        busy_d  = (state_d == RUN) || (state_d == FIX);
        done_d  = (state_q == FIX) || (state_q == ZERO);
        dz_d    = (state_q == ZERO);
    end

    // Iteration counter: cleared on accept, counts RUN cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     cnt_q <= '0;
        else if (load)  cnt_q <= '0;
        else if (step)  cnt_q <= cnt_q + CNT_W'(1);
    end

    // Handshake outputs are registered, never combinational from start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            dz_q   <= dz_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;

    muldiv_datapath #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .load_op (load_op),
        .a       (bus.a),
        .b       (bus.b),
        .step    (step),
        .fix     (fix),
        .hi      (bus.hi),
        .lo      (bus.lo)
    );

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: scoreboard of expected HI/LO/div_zero
// computed from 64-bit signed arithmetic, plus latency/handshake checks.
module tb_muldiv_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    int          total = 0;
    int          bad   = 0;
    exp_t        sb[$];
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    muldiv_if #(.WIDTH(32)) bus();

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic m, input logic [31:0] av, input logic [31:0] bv);
        exp_t   e;
        longint sa, sb2, p, q, r;
        sa  = longint'($signed(av));
        sb2 = longint'($signed(bv));
        if (m) begin
            p    = sa * sb2;
            e.hi = p[63:32];
            e.lo = p[31:0];
            e.dz = 1'b0;
        end else if (bv == 32'd0) begin
            e.hi = last_hi;
            e.lo = last_lo;
            e.dz = 1'b1;
        end else begin
            q    = sa / sb2;
            r    = sa % sb2;
            e.hi = r[31:0];
            e.lo = q[31:0];
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic push_exp(input logic m, input logic [31:0] av, input logic [31:0] bv);
        exp_t e;
        e = model(m, av, bv);
        sb.push_back(e);
        last_hi = e.hi;
        last_lo = e.lo;
    endtask

    // Pulse a start, wait (bounded) for done. inj>0 pulses an extra
    // start_div with b=0 just before edge E(inj).
    task automatic run_op(input logic m, input logic d, input logic [31:0] av,
                          input logic [31:0] bv, input int inj,
                          output int lat, output int busy_cyc,
                          output logic timed_out, output logic moved);
        logic [31:0] h0, l0;
        @(posedge clk); #1;
        bus.start_mult = m;
        bus.start_div  = d;
        bus.a          = av;
        bus.b          = bv;
        h0 = bus.hi;
        l0 = bus.lo;
        @(posedge clk); #1;
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.a          = $urandom;
        bus.b          = $urandom;
        lat       = 0;
        busy_cyc  = bus.busy ? 1 : 0;
        timed_out = 1'b1;
        moved     = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (c == inj) begin
                bus.start_div = 1'b1;
                bus.b         = 32'd0;
            end
            @(posedge clk); #1;
            bus.start_div = 1'b0;
            if (bus.done) begin
                lat       = c;
                timed_out = 1'b0;
                break;
            end
            if (bus.busy) busy_cyc++;
            if (bus.hi !== h0 || bus.lo !== l0) moved = 1'b1;
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        total++; if (bus.busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0)     begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        total++; if (bus.div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz: got %b want 0", bus.div_zero); end
        total++; if (bus.hi !== 32'd0)      begin bad++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
        total++; if (bus.lo !== 32'd0)      begin bad++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
    endtask

    // Runs a table of ops; full result + handshake checks on each.
    task automatic test_ops(input string name, input int n, input logic ms[8], input logic ds[8],
                            input logic [31:0] as[8], input logic [31:0] bs[8]);
        int   lat, bc;
        logic to, mv, zd;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            push_exp(ms[i], as[i], bs[i]);
            zd = !ms[i] && (bs[i] == 32'd0);
            run_op(ms[i], ds[i], as[i], bs[i], 0, lat, bc, to, mv);
            e = sb.pop_front();
            total++; if (to)              begin bad++; $display("FAIL %s[%0d] timeout: no done within 100 cycles", name, i); end
            total++; if (bus.hi !== e.hi) begin bad++; $display("FAIL %s[%0d] hi: got %h want %h", name, i, bus.hi, e.hi); end
            total++; if (bus.lo !== e.lo) begin bad++; $display("FAIL %s[%0d] lo: got %h want %h", name, i, bus.lo, e.lo); end
            total++; if (bus.div_zero !== e.dz) begin bad++; $display("FAIL %s[%0d] dz: got %b want %b", name, i, bus.div_zero, e.dz); end
            total++; if (lat != (zd ? 1 : 33)) begin bad++; $display("FAIL %s[%0d] latency: got %0d want %0d", name, i, lat, zd ? 1 : 33); end
            total++; if (bc != (zd ? 0 : 33))  begin bad++; $display("FAIL %s[%0d] busy_cycles: got %0d want %0d", name, i, bc, zd ? 0 : 33); end
            total++; if (mv)              begin bad++; $display("FAIL %s[%0d] hilo_moved_before_done: got 1 want 0", name, i); end
            @(posedge clk); #1;
            total++; if (bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
                bad++; $display("FAIL %s[%0d] pulse_width: done=%b dz=%b want 0 0", name, i, bus.done, bus.div_zero);
            end
        end
    endtask

    task automatic test_mult();
        logic        ms[8] = '{default: 1'b1};
        logic        ds[8] = '{default: 1'b0};
        logic [31:0] as[8] = '{32'd7, 32'h7FFFFFFF, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0};
        logic [31:0] bs[8] = '{32'hFFFFFFFD, 32'h7FFFFFFF, 32'h80000000, 32'h1234, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0};
        test_ops("mult", 5, ms, ds, as, bs);
    endtask

    task automatic test_div();
        logic        ms[8] = '{default: 1'b0};
        logic        ds[8] = '{default: 1'b1};
        logic [31:0] as[8] = '{32'hFFFFFFF9, 32'd7, 32'd7, 32'hFFFFFFF9, 32'd5, 32'd0, 32'd0, 32'd0};
        logic [31:0] bs[8] = '{32'd2, 32'hFFFFFFFE, 32'd7, 32'hFFFFFFFE, 32'd9, 32'd0, 32'd0, 32'd0};
        test_ops("div", 5, ms, ds, as, bs);
    endtask

    task automatic test_div_zero();
        logic        ms[8] = '{default: 1'b0};
        logic        ds[8] = '{default: 1'b1};
        logic [31:0] as[8] = '{32'h12345678, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        logic [31:0] bs[8] = '{default: 32'd0};
        test_ops("divzero", 2, ms, ds, as, bs);
    endtask

    task automatic test_div_ovf_priority();
        logic        ms[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        ds[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] as[8] = '{32'h80000000, 32'h10, 32'hFFFFFFFB, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        logic [31:0] bs[8] = '{32'hFFFFFFFF, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        test_ops("ovf_prio", 3, ms, ds, as, bs);
    endtask

    task automatic test_back_to_back();
        logic        ms[8];
        logic        ds[8];
        logic [31:0] as[8];
        logic [31:0] bs[8];
        for (int i = 0; i < 8; i++) begin
            ms[i] = (i % 2) == 0;
            ds[i] = !ms[i];
            as[i] = $urandom;
            bs[i] = (i % 4 == 1) ? $urandom_range(1, 1000) : $urandom;
            if (bs[i] == 32'd0) bs[i] = 32'd1;
        end
        test_ops("b2b", 8, ms, ds, as, bs);
    endtask

    task automatic test_ignore_start();
        int   lat, bc;
        logic to, mv;
        exp_t e;
        push_exp(1'b1, 32'd7, 32'hFFFFFFFD);
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 5, lat, bc, to, mv);
        e = sb.pop_front();
        total++; if (to)                 begin bad++; $display("FAIL ignore timeout: no done within 100 cycles"); end
        total++; if (bus.hi !== e.hi)    begin bad++; $display("FAIL ignore hi: got %h want %h", bus.hi, e.hi); end
        total++; if (bus.lo !== e.lo)    begin bad++; $display("FAIL ignore lo: got %h want %h", bus.lo, e.lo); end
        total++; if (bus.div_zero !== 1'b0) begin bad++; $display("FAIL ignore dz: got %b want 0", bus.div_zero); end
        total++; if (lat != 33)          begin bad++; $display("FAIL ignore latency: got %0d want 33", lat); end
        @(posedge clk); #1;
        total++; if (bus.done !== 1'b0)  begin bad++; $display("FAIL ignore extra_done: got %b want 0", bus.done); end
    endtask

    task automatic test_reset_midop();
        int seen;
        @(posedge clk); #1;
        bus.start_mult = 1'b1;
        bus.a          = 32'h7FFFFFFF;
        bus.b          = 32'h7FFFFFFF;
        @(posedge clk); #1;
        bus.start_mult = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midreset busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL midreset done: got %b want 0", bus.done); end
        total++; if (bus.hi !== 32'd0)  begin bad++; $display("FAIL midreset hi: got %h want 0", bus.hi); end
        total++; if (bus.lo !== 32'd0)  begin bad++; $display("FAIL midreset lo: got %h want 0", bus.lo); end
        last_hi = '0;
        last_lo = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL midreset resumed: got %0d active cycles want 0", seen); end
    endtask

    initial begin
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        reset          = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        #1 reset = 1'b1;
        test_mult();
        test_div();
        test_div_zero();
        test_div_ovf_priority();
        test_ignore_start();
        test_reset_midop();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
